// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the UART instruction-memory boot loader.
package imem_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_SYNC,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } ld_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle byte/frame-error strobes.
module uart_rx_byte
    import imem_loader_pkg::*;
#(
    parameter int CLK_DIV = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int TW = $clog2(CLK_DIV);
    // Start detection already costs one cycle, so the half-bit check lands one count early.
    localparam logic [TW-1:0] T_HALF = TW'(CLK_DIV / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(CLK_DIV - 1);

    rx_state_e      st, st_nxt;
    logic           rx_s1, rx_s2;
    logic [TW-1:0]  tmr;
    logic [2:0]     bit_idx;
    logic [7:0]     shreg;
    logic           half_hit, full_hit;

    assign half_hit  = (tmr == T_HALF);
    assign full_hit  = (tmr == T_FULL);
    assign byte_data = shreg;

    always_ff @(posedge clk) begin
        if (rst) st <= RX_IDLE;
        else     st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        case (st)
            RX_IDLE:  if (!rx_s2) st_nxt = RX_START;
            RX_START: if (half_hit) st_nxt = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (full_hit && bit_idx == 3'd7) st_nxt = RX_STOP;
            RX_STOP:  if (full_hit) st_nxt = RX_IDLE;
            default:  st_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            tmr        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_s1      <= rx;
            rx_s2      <= rx_s1;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (st)
                RX_IDLE: begin
                    tmr     <= '0;
                    bit_idx <= '0;
                end
                RX_START: tmr <= half_hit ? '0 : tmr + 1'b1;
                RX_DATA: begin
                    tmr <= full_hit ? '0 : tmr + 1'b1;
                    if (full_hit) begin
                        shreg   <= {rx_s2, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                RX_STOP: begin
                    tmr <= full_hit ? '0 : tmr + 1'b1;
                    if (full_hit) begin
                        byte_valid <= rx_s2;
                        frame_err  <= !rx_s2;
                    end
                end
                default: tmr <= '0;
            endcase
        end
    end

endmodule

// File: rtl/imem_uart_loader.sv
// Boot loader: framed UART image -> little-endian words -> instruction memory; holds core in reset until a good load.
module imem_uart_loader
    import imem_loader_pkg::*;
#(
    parameter int CLK_DIV = 868,
    parameter int ADDR_W  = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        uart_rx,
    output logic        im_we,
    output logic [31:0] im_addr,
    output logic [31:0] im_wd,
    output logic        core_rst,
    output logic        load_done,
    output logic        load_err
);

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    ld_state_e         state, state_nxt;
    logic              byte_valid, frame_err;
    logic [7:0]        byte_data;
    logic [15:0]       count;
    logic [ADDR_W:0]   word_index;
    logic [1:0]        byte_cnt;
    logic [23:0]       word_asm;
    logic [7:0]        csum;
    logic              is_sync, word_done, start;
    logic [16:0]       len_full;

    uart_rx_byte #(.CLK_DIV(CLK_DIV)) u_rx (
        .clk        (CLK),
        .rst        (RST),
        .rx         (uart_rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    assign is_sync   = byte_valid && (byte_data == SYNC_BYTE);
    assign len_full  = {1'b0, byte_data, count[7:0]};
    assign word_done = (17'(word_index) == {1'b0, count});
    assign start     = (state != S_LEN0) && (state_nxt == S_LEN0);

    always_ff @(posedge CLK) begin
        if (RST) state <= S_SYNC;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_SYNC: if (is_sync) state_nxt = S_LEN0;
            S_LEN0: if (byte_valid) state_nxt = S_LEN1;
            S_LEN1: if (byte_valid) begin
                if (len_full > MAX_WORDS)  state_nxt = S_ERR;
                else if (len_full == '0)   state_nxt = S_CSUM;
                else                       state_nxt = S_DATA;
            end
            // Leave only once the final write strobe has been issued, so im_we stays inside S_DATA.
            S_DATA: if (word_done) state_nxt = S_CSUM;
            S_CSUM: if (byte_valid) state_nxt = (byte_data == csum) ? S_DONE : S_ERR;
            S_DONE, S_ERR: if (is_sync) state_nxt = S_LEN0;
            default: state_nxt = S_SYNC;
        endcase
        if (frame_err && (state inside {S_LEN0, S_LEN1, S_DATA, S_CSUM}))
            state_nxt = S_ERR;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            im_we      <= 1'b0;
            im_addr    <= '0;
            im_wd      <= '0;
            core_rst   <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            count      <= '0;
            word_index <= '0;
            byte_cnt   <= '0;
            word_asm   <= '0;
            csum       <= '0;
        end else begin
            im_we     <= 1'b0;
            core_rst  <= (state_nxt != S_DONE);
            load_done <= (state_nxt == S_DONE);
            load_err  <= (state_nxt == S_ERR);
            if (start) begin
                csum       <= '0;
                word_index <= '0;
                byte_cnt   <= '0;
            end
            if (byte_valid) begin
                case (state)
                    S_LEN0: count[7:0]  <= byte_data;
                    S_LEN1: count[15:8] <= byte_data;
                    S_DATA: begin
                        csum     <= csum ^ byte_data;
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == 2'd3) begin
                            im_we      <= 1'b1;
                            im_addr    <= 32'(word_index[ADDR_W-1:0]) << 2;
                            im_wd      <= {byte_data, word_asm};
                            word_index <= word_index + 1'b1;
                        end else begin
                            word_asm[byte_cnt*8 +: 8] <= byte_data;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
